// File: rtl/multicycle_controller_pkg.sv
// ============================================================================
// Module      : multicycle_controller_pkg
// Description : Shared constants and types for the multicycle RV32I control
//               path: opcodes, ALU class codes, operand selects, trap causes,
//               FSM state encoding and the decoder result record.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_controller_pkg;

  localparam int XLEN    = 32;
  localparam int ALUOP_W = 3;
  localparam int SRC_W   = 2;

  // RV32I major opcodes (inst[6:0])
  localparam logic [6:0] c_OP_RTYPE = 7'b0110011;
  localparam logic [6:0] c_OP_ITYPE = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] c_OP_STORE = 7'b0100011;
  localparam logic [6:0] c_OP_BTYPE = 7'b1100011;
  localparam logic [6:0] c_OP_JAL   = 7'b1101111;
  localparam logic [6:0] c_OP_JALR  = 7'b1100111;
  localparam logic [6:0] c_OP_LUI   = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC = 7'b0010111;

  // ALU operation classes
  localparam logic [ALUOP_W-1:0] c_ALU_R      = 3'd0;
  localparam logic [ALUOP_W-1:0] c_ALU_I      = 3'd1;
  localparam logic [ALUOP_W-1:0] c_ALU_LS     = 3'd2;
  localparam logic [ALUOP_W-1:0] c_ALU_BRANCH = 3'd3;
  localparam logic [ALUOP_W-1:0] c_ALU_J      = 3'd4;
  localparam logic [ALUOP_W-1:0] c_ALU_U      = 3'd5;

  // Operand 2 selects
  localparam logic [SRC_W-1:0] c_SRC2_REG  = 2'd0;
  localparam logic [SRC_W-1:0] c_SRC2_IMM  = 2'd1;
  localparam logic [SRC_W-1:0] c_SRC2_FOUR = 2'd2;

  // Operand 1 selects
  localparam logic [SRC_W-1:0] c_SRC1_REG  = 2'd0;
  localparam logic [SRC_W-1:0] c_SRC1_PC   = 2'd1;
  localparam logic [SRC_W-1:0] c_SRC1_ZERO = 2'd2;

  // Trap causes
  localparam logic [1:0] c_CAUSE_NONE     = 2'd0;
  localparam logic [1:0] c_CAUSE_ILLEGAL  = 2'd1;
  localparam logic [1:0] c_CAUSE_FETCH_TO = 2'd2;
  localparam logic [1:0] c_CAUSE_DATA_TO  = 2'd3;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic [SRC_W-1:0]   alu_src;
    logic [SRC_W-1:0]   alu_src1;
    logic               pc_src;
    logic               legal;
  } dec_t;

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_if.sv
// ============================================================================
// Module      : multicycle_controller_if
// Description : Control bus between the multicycle controller and the
//               datapath / memory port.
//   inst, stall, mem_ready           : datapath/memory -> controller
//   mem_req, mem_read, mem_write     : memory request and qualifiers
//   ir_write, pc_write, pc_src,
//   branch, reg_write, mem_to_reg    : datapath strobes and selects
//   alu_op, alu_src, alu_src1        : ALU class and operand selects
//   trap, trap_cause                 : sticky fault status
//   modport master : the controller; modport slave : datapath/memory side
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_controller_if;
  import multicycle_controller_pkg::*;

  logic [XLEN-1:0]    inst;
  logic               stall;
  logic               mem_ready;
  logic               mem_req;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               pc_write;
  logic               pc_src;
  logic               branch;
  logic [ALUOP_W-1:0] alu_op;
  logic [SRC_W-1:0]   alu_src;
  logic [SRC_W-1:0]   alu_src1;
  logic               mem_to_reg;
  logic               reg_write;
  logic               trap;
  logic [1:0]         trap_cause;

  modport master (
    input  inst, stall, mem_ready,
    output mem_req, mem_read, mem_write, ir_write, pc_write, pc_src, branch,
           alu_op, alu_src, alu_src1, mem_to_reg, reg_write, trap, trap_cause
  );

  modport slave (
    output inst, stall, mem_ready,
    input  mem_req, mem_read, mem_write, ir_write, pc_write, pc_src, branch,
           alu_op, alu_src, alu_src1, mem_to_reg, reg_write, trap, trap_cause
  );

endinterface

`default_nettype wire

// File: rtl/multicycle_controller_ctrl_decode.sv
// ============================================================================
// Module      : ctrl_decode
// Description : Combinational opcode decoder; same table as the single-cycle
//               decoder.
//   i_opcode : latched inst[6:0]
//   o_dec    : {alu_op, alu_src, alu_src1, pc_src, legal}
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_decode
  import multicycle_controller_pkg::*;
(
  input  logic [6:0] i_opcode,
  output dec_t       o_dec
);

  always_comb begin
    o_dec = '0;
    case (i_opcode)
      c_OP_RTYPE: o_dec = '{c_ALU_R,      c_SRC2_REG,  c_SRC1_REG,  1'b0, 1'b1};
      c_OP_ITYPE: o_dec = '{c_ALU_I,      c_SRC2_IMM,  c_SRC1_REG,  1'b0, 1'b1};
      c_OP_LOAD,
      c_OP_STORE: o_dec = '{c_ALU_LS,     c_SRC2_IMM,  c_SRC1_REG,  1'b0, 1'b1};
      c_OP_BTYPE: o_dec = '{c_ALU_BRANCH, c_SRC2_REG,  c_SRC1_REG,  1'b0, 1'b1};
      // Jumps compute the link value PC+4; the target comes via pc_src.
      c_OP_JAL:   o_dec = '{c_ALU_J,      c_SRC2_FOUR, c_SRC1_PC,   1'b0, 1'b1};
      c_OP_JALR:  o_dec = '{c_ALU_J,      c_SRC2_FOUR, c_SRC1_PC,   1'b1, 1'b1};
      c_OP_LUI:   o_dec = '{c_ALU_U,      c_SRC2_IMM,  c_SRC1_ZERO, 1'b0, 1'b1};
      c_OP_AUIPC: o_dec = '{c_ALU_U,      c_SRC2_IMM,  c_SRC1_PC,   1'b0, 1'b1};
      default:    o_dec = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module      : multicycle_controller
// Description : Multicycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP)
//               with memory wait timeout and illegal-opcode trap.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : control bus (master modport), see multicycle_controller_if
//   MAX_WAIT : cycles a request may wait for mem_ready before trapping
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input logic                     clk,
  input logic                     rst,
  multicycle_controller_if.master bus
);

  localparam int                  c_WAIT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LIMIT = c_WAIT_W'(MAX_WAIT);

  state_t              r_state, w_state_nxt;
  logic [6:0]          r_opcode;
  logic [c_WAIT_W-1:0] r_wait;
  dec_t                w_dec;

  logic               r_mem_req,  w_mem_req_nxt;
  logic               r_mem_read, w_mem_read_nxt;
  logic               r_mem_write, w_mem_write_nxt;
  logic               r_pc_write, w_pc_write_nxt;
  logic               r_branch,   w_branch_nxt;
  logic               r_reg_write, w_reg_write_nxt;
  logic               r_mem_to_reg, w_mem_to_reg_nxt;
  logic               r_trap,     w_trap_nxt;
  logic [1:0]         r_trap_cause, w_cause_nxt;
  logic [ALUOP_W-1:0] r_alu_op,   w_alu_op_nxt;
  logic [SRC_W-1:0]   r_alu_src,  w_alu_src_nxt;
  logic [SRC_W-1:0]   r_alu_src1, w_alu_src1_nxt;
  logic               r_pc_src,   w_pc_src_nxt;

  logic w_done, w_timeout, w_is_load, w_is_store, w_is_branch, w_alu_live;
  logic w_unused;

  // Only the opcode field is consumed here; the rest goes to the IR.
  assign w_unused = ^bus.inst[XLEN-1:7];

  ctrl_decode u_decode (
    .i_opcode (r_opcode),
    .o_dec    (w_dec)
  );

  // A ready is only meaningful while our own request is outstanding.
  assign w_done      = r_mem_req & bus.mem_ready;
  assign w_timeout   = r_mem_req & ~bus.mem_ready & (r_wait == c_WAIT_LIMIT);
  assign w_is_load   = (r_opcode == c_OP_LOAD);
  assign w_is_store  = (r_opcode == c_OP_STORE);
  assign w_is_branch = (r_opcode == c_OP_BTYPE);

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_trap_cause;
    case (r_state)
      ST_FETCH: begin
        if (w_done) begin
          w_state_nxt = ST_DECODE;
        end else if (w_timeout) begin
          w_state_nxt = ST_TRAP;
          w_cause_nxt = c_CAUSE_FETCH_TO;
        end
      end
      ST_DECODE: begin
        if (w_dec.legal) begin
          w_state_nxt = ST_EXEC;
        end else begin
          w_state_nxt = ST_TRAP;
          w_cause_nxt = c_CAUSE_ILLEGAL;
        end
      end
      ST_EXEC: begin
        if (w_is_branch)                  w_state_nxt = ST_FETCH;
        else if (w_is_load || w_is_store) w_state_nxt = ST_MEM;
        else                              w_state_nxt = ST_WB;
      end
      ST_MEM: begin
        if (w_done) begin
          w_state_nxt = w_is_load ? ST_WB : ST_FETCH;
        end else if (w_timeout) begin
          w_state_nxt = ST_TRAP;
          w_cause_nxt = c_CAUSE_DATA_TO;
        end
      end
      ST_WB:   w_state_nxt = ST_FETCH;
      ST_TRAP: w_state_nxt = ST_TRAP;
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  // Output look-ahead: every level output is computed for the state being
  // entered and registered, so outputs never depend combinationally on inst.
  always_comb begin
    w_mem_req_nxt    = 1'b0;
    w_mem_read_nxt   = 1'b0;
    w_mem_write_nxt  = 1'b0;
    w_pc_write_nxt   = 1'b0;
    w_branch_nxt     = 1'b0;
    w_reg_write_nxt  = 1'b0;
    w_mem_to_reg_nxt = 1'b0;
    w_trap_nxt       = 1'b0;
    w_alu_live       = 1'b0;
    case (w_state_nxt)
      ST_FETCH: begin
        // An outstanding fetch is held until ready; a new one only starts
        // when the datapath is not stalling.
        w_mem_req_nxt  = (r_state == ST_FETCH && r_mem_req) ? 1'b1 : ~bus.stall;
        w_mem_read_nxt = w_mem_req_nxt;
      end
      ST_EXEC: begin
        w_alu_live     = 1'b1;
        w_branch_nxt   = w_is_branch;
        w_pc_write_nxt = w_is_branch;
      end
      ST_MEM: begin
        w_alu_live      = 1'b1;
        w_mem_req_nxt   = 1'b1;
        w_mem_read_nxt  = w_is_load;
        w_mem_write_nxt = w_is_store;
      end
      ST_WB: begin
        w_alu_live       = 1'b1;
        w_reg_write_nxt  = 1'b1;
        w_pc_write_nxt   = 1'b1;
        w_mem_to_reg_nxt = w_is_load;
      end
      ST_TRAP: w_trap_nxt = 1'b1;
      default: w_trap_nxt = 1'b0;
    endcase
    w_alu_op_nxt   = w_alu_live ? w_dec.alu_op   : '0;
    w_alu_src_nxt  = w_alu_live ? w_dec.alu_src  : '0;
    w_alu_src1_nxt = w_alu_live ? w_dec.alu_src1 : '0;
    w_pc_src_nxt   = w_alu_live & w_dec.pc_src;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_FETCH;
      r_opcode     <= '0;
      r_wait       <= '0;
      r_mem_req    <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_pc_write   <= 1'b0;
      r_branch     <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_trap       <= 1'b0;
      r_trap_cause <= c_CAUSE_NONE;
      r_alu_op     <= '0;
      r_alu_src    <= '0;
      r_alu_src1   <= '0;
      r_pc_src     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_read   <= w_mem_read_nxt;
      r_mem_write  <= w_mem_write_nxt;
      r_pc_write   <= w_pc_write_nxt;
      r_branch     <= w_branch_nxt;
      r_reg_write  <= w_reg_write_nxt;
      r_mem_to_reg <= w_mem_to_reg_nxt;
      r_trap       <= w_trap_nxt;
      r_trap_cause <= w_cause_nxt;
      r_alu_op     <= w_alu_op_nxt;
      r_alu_src    <= w_alu_src_nxt;
      r_alu_src1   <= w_alu_src1_nxt;
      r_pc_src     <= w_pc_src_nxt;
      if (r_state == ST_FETCH && w_done) r_opcode <= bus.inst[6:0];
      if (w_done)         r_wait <= '0;
      else if (r_mem_req) r_wait <= r_wait + 1'b1;
    end
  end

  // Handshake-completion strobes must coincide with the ready cycle so the
  // datapath captures inst / commits the store on that edge; they are gated
  // by rst so a reset arriving together with ready commits nothing.
  assign bus.ir_write   = ~rst & w_done & (r_state == ST_FETCH);
  assign bus.pc_write   = r_pc_write | (~rst & w_done & (r_state == ST_MEM) & w_is_store);
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_read   = r_mem_read;
  assign bus.mem_write  = r_mem_write;
  assign bus.branch     = r_branch;
  assign bus.reg_write  = r_reg_write;
  assign bus.mem_to_reg = r_mem_to_reg;
  assign bus.trap       = r_trap;
  assign bus.trap_cause = r_trap_cause;
  assign bus.alu_op     = r_alu_op;
  assign bus.alu_src    = r_alu_src;
  assign bus.alu_src1   = r_alu_src1;
  assign bus.pc_src     = r_pc_src;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Self-checking bench for multicycle_controller. An instruction
//               level model expands each instruction (class, fetch waits,
//               data waits) into the expected per-cycle control trace.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_controller_if bus();

  multicycle_controller #(.MAX_WAIT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Observed control vector: {req,rd,wr,ir,pw,br,rw,m2r,trap,cause[1:0]}
  localparam logic [10:0] REQ = 11'h400, RD = 11'h200, WR = 11'h100, IR = 11'h080,
                          PW  = 11'h040, BR = 11'h020, RW = 11'h010, M2R = 11'h008,
                          TRP = 11'h004, NONE = 11'h000;

  wire [10:0] obs = {bus.mem_req, bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write,
                     bus.branch, bus.reg_write, bus.mem_to_reg, bus.trap, bus.trap_cause};
  wire [8:0]  obs_alu = {bus.alu_op, bus.alu_src, bus.alu_src1, bus.pc_src};

  typedef struct {
    logic        rdy;
    logic        stl;
    logic [31:0] inst;
    logic [10:0] exp;
    logic        chk_alu;
    logic [8:0]  alu;
  } cyc_t;

  cyc_t q[$];
  int tests = 0;
  int fails = 0;
  int cyc_no = 0;

  logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

  function automatic logic rb();
    return ($urandom % 2) == 1;
  endfunction

  // Decoder table: {alu_op, alu_src, alu_src1, pc_src}
  function automatic logic [8:0] alu_ref(input logic [6:0] op);
    case (op)
      7'h33:        return {3'd0, 2'd0, 2'd0, 1'b0};
      7'h13:        return {3'd1, 2'd1, 2'd0, 1'b0};
      7'h03, 7'h23: return {3'd2, 2'd1, 2'd0, 1'b0};
      7'h63:        return {3'd3, 2'd0, 2'd0, 1'b0};
      7'h6F:        return {3'd4, 2'd2, 2'd1, 1'b0};
      7'h67:        return {3'd4, 2'd2, 2'd1, 1'b1};
      7'h37:        return {3'd5, 2'd1, 2'd2, 1'b0};
      7'h17:        return {3'd5, 2'd1, 2'd1, 1'b0};
      default:      return 9'd0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    for (int i = 0; i < 9; i++) if (ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push(input logic rdy, input logic stl, input logic [31:0] w,
                      input logic [10:0] e, input logic ca, input logic [8:0] a);
    cyc_t c;
    c.rdy = rdy; c.stl = stl; c.inst = w; c.exp = e; c.chk_alu = ca; c.alu = a;
    q.push_back(c);
  endtask

  task automatic add_idle(input int n, input logic stl);
    for (int i = 0; i < n; i++) push(rb(), stl, $urandom, NONE, 1'b0, 9'd0);
  endtask

  task automatic add_trap(input logic [1:0] cause, input int n);
    for (int i = 0; i < n; i++) push(rb(), rb(), $urandom, TRP | {9'd0, cause}, 1'b0, 9'd0);
  endtask

  // Wait counts of 16 (one beyond MAX_WAIT) model a request that never
  // completes; the caller appends the trap cycles.
  task automatic add_instr(input logic [31:0] w, input int fw, input int dw);
    logic [6:0] op;
    logic ld, st, br;
    op = w[6:0];
    ld = (op == 7'h03);
    st = (op == 7'h23);
    br = (op == 7'h63);
    for (int i = 0; i < fw && i < 16; i++) push(1'b0, 1'b0, $urandom, REQ | RD, 1'b0, 9'd0);
    if (fw >= 16) return;
    push(1'b1, 1'b0, w, REQ | RD | IR, 1'b0, 9'd0);
    push(rb(), 1'b0, $urandom, NONE, 1'b0, 9'd0);
    if (!is_legal(op)) return;
    push(rb(), 1'b0, $urandom, br ? (BR | PW) : NONE, 1'b1, alu_ref(op));
    if (ld || st) begin
      for (int i = 0; i < dw && i < 16; i++)
        push(1'b0, 1'b0, $urandom, REQ | (ld ? RD : NONE) | (st ? WR : NONE), 1'b0, 9'd0);
      if (dw >= 16) return;
      push(1'b1, 1'b0, $urandom, REQ | (ld ? RD : NONE) | (st ? (WR | PW) : NONE), 1'b0, 9'd0);
      if (ld) push(rb(), 1'b0, $urandom, RW | PW | M2R, 1'b0, 9'd0);
    end else if (!br) begin
      push(rb(), 1'b0, $urandom, RW | PW, 1'b0, 9'd0);
    end
  endtask

  // Entered and left at posedge+1.
  task automatic run_q(input string tag);
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      bus.mem_ready = c.rdy;
      bus.stall     = c.stl;
      bus.inst      = c.inst;
      @(negedge clk);
      tests++;
      assert (obs === c.exp) else begin
        fails++;
        $error("FAIL %s cycle %0d ctrl got %h exp %h", tag, cyc_no, obs, c.exp);
      end
      if (c.chk_alu) begin
        tests++;
        assert (obs_alu === c.alu) else begin
          fails++;
          $error("FAIL %s_alu cycle %0d got %h exp %h", tag, cyc_no, obs_alu, c.alu);
        end
      end
      cyc_no++;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    bus.stall = 1'b0;
    bus.inst = 32'h0;
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    assert ({obs, obs_alu} === 20'd0) else begin
      fails++;
      $error("FAIL reset got %h/%h exp 0/0", obs, obs_alu);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got no completion exp finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // addi, then lw with 3 waits, beq, lw ready exactly at the wait limit
    do_reset();
    add_idle(1, 1'b0);
    add_instr(32'h00500093, 0, 0);
    add_instr(32'h0000A103, 0, 3);
    add_instr(32'h00000063, 0, 0);
    add_instr(32'h0000A103, 0, 15);
    add_instr(32'h0020A023, 2, 1);
    run_q("basic");

    // illegal opcode traps after DECODE and holds for 20 cycles
    add_instr(32'h0000007F, 1, 0);
    add_trap(2'd1, 20);
    run_q("illegal");

    // reset clears the trap; fetch ready at the limit, then fetch timeout
    do_reset();
    add_idle(1, 1'b0);
    add_instr(32'h00500093, 15, 0);
    add_instr(32'h00500093, 16, 0);
    add_trap(2'd2, 5);
    run_q("fetch_to");

    // data timeout on a store
    do_reset();
    add_idle(1, 1'b0);
    add_instr(32'h0020A023, 0, 16);
    add_trap(2'd3, 5);
    run_q("data_to");

    // stall holds FETCH without a request
    do_reset();
    add_idle(5, 1'b1);
    add_idle(1, 1'b0);
    add_instr(32'h00500093, 0, 0);
    run_q("stall");

    // reset during a store's MEM wait, with ready arriving in the reset cycle
    do_reset();
    add_idle(1, 1'b0);
    add_instr(32'h0020A023, 0, 16);
    while (q.size() > 6) void'(q.pop_back());
    run_q("sw_wait");
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    tests++;
    assert ({bus.ir_write, bus.pc_write, bus.reg_write} === 3'b000) else begin
      fails++;
      $error("FAIL rst_nopulse got %b exp 000", {bus.ir_write, bus.pc_write, bus.reg_write});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    assert (obs === NONE) else begin
      fails++;
      $error("FAIL rst_drop got %h exp %h", obs, NONE);
    end
    @(posedge clk); #1;
    add_instr(32'h00500093, 0, 0);
    run_q("after_rst");

    // randomized instruction stream
    do_reset();
    add_idle(1, 1'b0);
    for (int n = 0; n < 40; n++) begin
      logic [31:0] r;
      r = $urandom;
      add_instr({r[31:7], ops[$urandom_range(8, 0)]},
                int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
    end
    run_q("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
